// File: rtl/nist_pkg.sv
// rtl/nist_pkg.sv - shared state encoding, default parameters and helpers for the NIST sequencer
package nist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARM,
        ST_RUN,
        ST_EVAL,
        ST_DONE
    } state_t;

    localparam int DEF_BLK_LEN  = 128;
    localparam int DEF_NUM_BLKS = 128;
    localparam int DEF_MAX_FAIL = 5;
    localparam int DEF_WARMUP   = 16;

    localparam logic [3:0] FAIL_SAT = 4'd15;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == FAIL_SAT) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/nist_run_counter.sv
// rtl/nist_run_counter.sv - bit-within-block and block-within-run counters with terminal-count flags
module nist_run_counter
    import nist_pkg::*;
#(
    parameter int BLK_LEN  = DEF_BLK_LEN,
    parameter int NUM_BLKS = DEF_NUM_BLKS
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_bit_inc,
    input  logic i_blk_inc,
    output logic o_bit_tc,
    output logic o_blk_last
);

    localparam int BW = $clog2(BLK_LEN) + 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(BLK_LEN - 1);
    localparam logic [7:0]    BLK_LAST = 8'(NUM_BLKS - 1);

    logic [BW-1:0] r_bit_cnt;
    logic [7:0]    r_blk_cnt;

    // Terminal count fires on the cycle that accepts the last bit of the block,
    // and the counter wraps so the next block starts from zero.
    assign o_bit_tc   = i_bit_inc && (r_bit_cnt == BIT_LAST);
    assign o_blk_last = (r_blk_cnt == BLK_LAST);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_bit_cnt <= '0;
            r_blk_cnt <= '0;
        end else begin
            if (i_bit_inc) begin
                r_bit_cnt <= o_bit_tc ? '0 : r_bit_cnt + BW'(1);
            end
            if (i_blk_inc) begin
                r_blk_cnt <= r_blk_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/nist_test_sequencer.sv
// rtl/nist_test_sequencer.sv - run sequencer for a block-wise monobit randomness health test
module nist_test_sequencer
    import nist_pkg::*;
#(
    parameter int BLK_LEN  = DEF_BLK_LEN,
    parameter int NUM_BLKS = DEF_NUM_BLKS,
    parameter int MAX_FAIL = DEF_MAX_FAIL,
    parameter int WARMUP   = DEF_WARMUP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       rnd_valid,
    input  logic       blk_ok,
    output logic       rnd_en,
    output logic       bit_en,
    output logic       blk_clr,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_cnt
);

    localparam logic [3:0] MAX_FAIL_V  = 4'(MAX_FAIL);
    localparam logic [7:0] WARM_LAST_V = 8'(WARMUP - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_warm_cnt;
    logic [3:0] r_fail_cnt;
    logic       r_pass;

    logic       w_abort_run;
    logic       w_start_go;
    logic       w_warm_last;
    logic       w_bit_tc;
    logic       w_blk_last;
    logic       w_cnt_clr;
    logic       w_blk_inc;
    logic [3:0] w_fail_upd;

    assign w_abort_run = abort && (r_state != ST_IDLE);
    assign w_start_go  = (r_state == ST_IDLE) && start && !abort;
    assign w_warm_last = rnd_valid && (r_warm_cnt == WARM_LAST_V);
    assign w_fail_upd  = blk_ok ? r_fail_cnt : sat_inc4(r_fail_cnt);
    assign w_cnt_clr   = w_start_go || w_abort_run;
    assign w_blk_inc   = (r_state == ST_EVAL) && !abort;

    nist_run_counter #(
        .BLK_LEN  (BLK_LEN),
        .NUM_BLKS (NUM_BLKS)
    ) u_run_counter (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_cnt_clr),
        .i_bit_inc  (bit_en),
        .i_blk_inc  (w_blk_inc),
        .o_bit_tc   (w_bit_tc),
        .o_blk_last (w_blk_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        rnd_en      = 1'b0;
        bit_en      = 1'b0;
        blk_clr     = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                busy    = 1'b0;
                blk_clr = 1'b1;
                if (w_start_go) begin
                    w_state_nxt = (WARMUP == 0) ? ST_RUN : ST_WARM;
                end
            end
            ST_WARM: begin
                rnd_en = 1'b1;
                if (w_warm_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                rnd_en = 1'b1;
                bit_en = rnd_valid;
                if (w_bit_tc) begin
                    w_state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: begin
                blk_clr = 1'b1;
                if (w_blk_last || (w_fail_upd > MAX_FAIL_V)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                done        = !abort;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Abort overrides every transition; the landing IDLE state holds blk_clr.
        if (w_abort_run) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_warm_cnt <= '0;
            r_fail_cnt <= '0;
            r_pass     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_go) begin
                r_warm_cnt <= '0;
                r_fail_cnt <= '0;
            end else begin
                if ((r_state == ST_WARM) && rnd_valid) begin
                    r_warm_cnt <= r_warm_cnt + 8'd1;
                end
                if ((r_state == ST_EVAL) && !abort) begin
                    r_fail_cnt <= w_fail_upd;
                end
            end
            if ((r_state == ST_DONE) && !abort) begin
                r_pass <= (r_fail_cnt <= MAX_FAIL_V);
            end
        end
    end

    assign pass     = r_pass;
    assign fail_cnt = r_fail_cnt;

endmodule

// File: tb/tb_nist_test_sequencer.sv
// tb/tb_nist_test_sequencer.sv - directed self-checking bench for nist_test_sequencer
module tb_nist_test_sequencer;

    localparam int FULL_CYC  = 16 + 128 * 129 + 1;
    localparam int EARLY_CYC = 16 + 6 * 129 + 1;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       rnd_valid;
    logic       blk_ok;
    logic       rnd_en;
    logic       bit_en;
    logic       blk_clr;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_cnt;

    int           n_checks;
    int           n_errors;
    int           eval_idx;
    bit           toggle;
    logic [255:0] fail_mask;

    nist_test_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .rnd_valid (rnd_valid),
        .blk_ok    (blk_ok),
        .rnd_en    (rnd_en),
        .bit_en    (bit_en),
        .blk_clr   (blk_clr),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_cnt  (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Random source and block verdict model; busy with blk_clr marks the EVAL cycle.
    always @(posedge clk) begin
        #2;
        rnd_valid = toggle ? ~rnd_valid : 1'b1;
        if (busy && blk_clr) begin
            blk_ok   = !fail_mask[eval_idx];
            eval_idx = eval_idx + 1;
        end else begin
            blk_ok = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_run(input string tag, input logic [255:0] mask, input int exp_cyc,
                          input int exp_evals, input int exp_fail, input logic exp_pass);
        int cyc;
        bit seen;
        fail_mask = mask;
        eval_idx  = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc <= 20000) begin
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_len"}, cyc, exp_cyc);
        chk({tag, "_evals"}, eval_idx, exp_evals);
        chk({tag, "_fail_cnt"}, 32'(fail_cnt), exp_fail);
        @(negedge clk);
        chk({tag, "_pass"}, 32'(pass), 32'(exp_pass));
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        if (!seen) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
    endtask

    initial begin
        int cyc;
        int bits;
        int n_ev;
        int ev_cyc[3];
        int ev_bits[3];
        int done_hits;
        int first_bit;
        logic [255:0] m;

        n_checks  = 0;
        n_errors  = 0;
        eval_idx  = 0;
        toggle    = 1'b0;
        fail_mask = '0;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        rnd_valid = 1'b1;
        blk_ok    = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("rst_rnd_en", 32'(rnd_en), 32'd0);
        chk("rst_bit_en", 32'(bit_en), 32'd0);
        chk("rst_blk_clr", 32'(blk_clr), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("idle_abort_start_busy", 32'(busy), 32'd0);

        do_run("full_ok", '0, FULL_CYC, 128, 0, 1'b1);

        m = '0;
        m[3] = 1'b1;
        m[7] = 1'b1;
        do_run("two_fail", m, FULL_CYC, 128, 2, 1'b1);

        // Abort in block 10 with block 0 failed, then restart and probe start-while-busy.
        m = '0;
        m[0] = 1'b1;
        fail_mask = m;
        eval_idx  = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (eval_idx < 10 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reach_blk10", eval_idx, 10);
        repeat (5) @(negedge clk);
        chk("abort_pre_fail_cnt", 32'(fail_cnt), 32'd1);
        chk("abort_pre_rnd_en", 32'(rnd_en), 32'd1);
        abort = 1'b1;
        done_hits = done ? 1 : 0;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_blk_clr", 32'(blk_clr), 32'd1);
        chk("abort_rnd_en", 32'(rnd_en), 32'd0);
        chk("abort_pass_kept", 32'(pass), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (done) done_hits++;
            @(negedge clk);
        end
        chk("abort_no_done", done_hits, 0);

        fail_mask = '0;
        eval_idx  = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_warm_bit_en", 32'(bit_en), 32'd0);
        cyc = 1;
        first_bit = 0;
        while (first_bit == 0 && cyc < 100) begin
            if (cyc == 5) start = 1'b1;
            if (cyc == 6) start = 1'b0;
            if (bit_en) first_bit = cyc;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        chk("warm_len_ignore_start", first_bit, 17);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // Reset landing on the EVAL cycle.
        eval_idx = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(busy && blk_clr) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_eval_reached", 32'(busy && blk_clr), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_eval_busy", 32'(busy), 32'd0);
        chk("rst_eval_done", 32'(done), 32'd0);
        chk("rst_eval_pass", 32'(pass), 32'd0);
        chk("rst_eval_rnd_en", 32'(rnd_en), 32'd0);
        chk("rst_eval_bit_en", 32'(bit_en), 32'd0);
        chk("rst_eval_blk_clr", 32'(blk_clr), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        do_run("early_fail", '1, EARLY_CYC, 6, 6, 1'b0);

        // Alternating rnd_valid: EVAL-to-EVAL spacing and bits per block.
        toggle   = 1'b1;
        eval_idx = 0;
        fail_mask = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc  = 1;
        bits = 0;
        n_ev = 0;
        while (n_ev < 3 && cyc < 2000) begin
            if (bit_en) bits++;
            if (busy && blk_clr) begin
                ev_cyc[n_ev]  = cyc;
                ev_bits[n_ev] = bits;
                bits = 0;
                n_ev++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("tog_evals", n_ev, 3);
        if (n_ev == 3) begin
            chk("tog_bits_blk0", ev_bits[0], 128);
            chk("tog_bits_blk1", ev_bits[1], 128);
            chk("tog_bits_blk2", ev_bits[2], 128);
            chk("tog_span_blk1", ev_cyc[1] - ev_cyc[0], 256);
            chk("tog_span_blk2", ev_cyc[2] - ev_cyc[1], 256);
        end
        abort = 1'b1;
        @(negedge clk);
        abort  = 1'b0;
        toggle = 1'b0;
        chk("tog_abort_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
